// File: rtl/mem_model_pipe.sv
// mem_model_pipe: behavioural memory with a valid/ready request channel and an in-order,
// backpressure-tolerant read response channel.
//
// After reset an init sweep writes INIT_VALUE to every word, one per cycle. Requests are
// then accepted. Writes are byte-enabled and produce no response. Reads travel through a
// READ_LATENCY-deep pipeline into a response FIFO of READ_LATENCY+1 entries. Credits
// guarantee the FIFO can never overflow.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   req_valid  request present               req_ready  request accepted this edge
//   req_write  1 = write, 0 = read           req_addr   word address
//   req_wdata  write data                    req_be     byte enables
//   rsp_valid  read data available           rsp_ready  response consumed this edge
//   rsp_rdata  read data, in request order   init_done  init sweep finished
module mem_model_pipe #(
    parameter int unsigned            ADDR_WIDTH   = 4,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      init_done
);

    localparam int unsigned Depth     = 2 ** ADDR_WIDTH;
    localparam int unsigned NumBytes  = DATA_WIDTH / 8;
    localparam int unsigned FifoDepth = READ_LATENCY + 1;
    localparam int unsigned PtrW      = $clog2(FifoDepth);
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);
    localparam int unsigned CmpW      = CntW + 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                  run;

    logic                  pop, req_acc, rd_acc, wr_acc, push;
    logic [CmpW-1:0]       credit_limit;

    logic [CntW-1:0]       outstanding_q, outstanding_d;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NumBytes-1:0]   mem_wbe;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_dat_d [READ_LATENCY];

    logic [DATA_WIDTH-1:0] fifo_q [FifoDepth];
    logic [DATA_WIDTH-1:0] fifo_d [FifoDepth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- init FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        unique case (state_q)
            StInit: begin
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        run       = (state_q == StRun);
        init_done = run;
    end

    // ---------------------------------------------------------------- handshakes and credits
    always_comb begin
        rsp_valid = (count_q != '0);
        rsp_rdata = fifo_q[rd_ptr_q];
        pop       = rsp_valid && rsp_ready;
        // A pop this cycle frees a slot, so one more request may be accepted alongside it.
        credit_limit = CmpW'(FifoDepth) + {{CntW{1'b0}}, pop};
        req_ready    = run && ({1'b0, outstanding_q} < credit_limit);
        req_acc      = req_valid && req_ready;
        rd_acc       = req_acc && !req_write;
        wr_acc       = req_acc && req_write;
        push         = pipe_vld_q[READ_LATENCY-1];
    end

    // ---------------------------------------------------------------- storage array
    always_comb begin
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr_q;
            mem_wdata = INIT_VALUE;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr_acc;
            mem_waddr = req_addr;
            mem_wdata = req_wdata;
            mem_wbe   = req_be;
        end
    end

    // Array contents deliberately survive reset; the init sweep rewrites them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read pipeline
    // Stage 0 samples the array on the accept edge; the last stage feeds the FIFO.
    always_comb begin
        pipe_vld_d    = (pipe_vld_q << 1) | READ_LATENCY'(rd_acc);
        pipe_dat_d    = pipe_dat_q;
        pipe_dat_d[0] = mem_q[req_addr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
    end

    // ---------------------------------------------------------------- response FIFO
    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = pipe_dat_q[READ_LATENCY-1];
        end
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q + CntW'(push) - CntW'(pop);
        outstanding_d = outstanding_q + CntW'(rd_acc) - CntW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q    <= '0;
            pipe_dat_q    <= '{default: '0};
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            pipe_dat_q    <= pipe_dat_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_mem_model_pipe.sv
// Testbench for mem_model_pipe: directed stimulus, a queue-based reference model checked
// on every cycle, and hand-computed literal expectations for the main scenarios.
module tb_mem_model_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int L     = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;

    always #5 clk = ~clk;

    mem_model_pipe #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (L),
        .INIT_VALUE   ('1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Every accepted, unconsumed read sits in a queue with the cycle at which it may
    // first be presented; outstanding credits are simply the queue length.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] q_data [$];
    int          q_avail [$];
    bit          m_run = 1'b0;
    int          m_init_cnt = 0;
    int          m_cyc = 0;

    function automatic bit m_valid();
        return (q_data.size() > 0) && (q_avail[0] <= m_cyc);
    endfunction

    function automatic bit m_ready();
        int occ;
        occ = q_data.size() - ((m_valid() && rsp_ready) ? 1 : 0);
        return m_run && (occ < L + 1);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q_data.delete();
                q_avail.delete();
                m_run      = 1'b0;
                m_init_cnt = 0;
            end else begin
                bit pop, acc;
                pop = m_valid() && rsp_ready;
                acc = req_valid && m_ready();
                m_cyc++;
                if (pop) begin
                    void'(q_data.pop_front());
                    void'(q_avail.pop_front());
                end
                if (!m_run) begin
                    m_init_cnt++;
                    if (m_init_cnt == DEPTH) begin
                        m_run = 1'b1;
                        for (int a = 0; a < DEPTH; a++) m_mem[a] = 32'hFFFF_FFFF;
                    end
                end else if (acc) begin
                    if (req_write) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end else begin
                        q_data.push_back(m_mem[req_addr]);
                        q_avail.push_back(m_cyc + L);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- per-cycle compare
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_req_ready", req_ready, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_rdata", rsp_rdata, 0);
                check("rst_init_done", init_done, 0);
            end else begin
                check("req_ready", req_ready, m_ready());
                check("init_done", init_done, m_run);
                check("rsp_valid", rsp_valid, m_valid());
                if (m_valid()) check("rsp_rdata", rsp_rdata, q_data[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic cyc(input bit v, input bit w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        @(posedge clk);
        #1;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    // Called just after reset release; spans exactly the 16 sweep edges.
    task automatic sweep_check(input string tag);
        int low   = 0;
        int early = 0;
        int vld   = 0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!req_ready) low++;
            if (init_done) early++;
            if (rsp_valid) vld++;
            idle(1);
        end
        check({tag, "_ready_low_cycles"}, low, 16);
        check({tag, "_init_done_early"}, early, 0);
        check({tag, "_rsp_during_init"}, vld, 0);
        check({tag, "_init_done_c17"}, init_done, 1);
        check({tag, "_ready_after_init"}, req_ready, 1);
    endtask

    logic [31:0] t3_exp [4];

    initial begin
        int cnt, vcnt;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        idle(3);
        check("reset_ready", req_ready, 0);
        check("reset_init_done", init_done, 0);

        // 1: init sweep, then every word reads back as all ones
        reset_n = 1'b1;
        sweep_check("t1");
        cnt  = 0;
        vcnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b1, 1'b0, 4'(a), 32'd0, 4'hF);
            if (req_ready) cnt++;
            if (rsp_valid && rsp_rdata == 32'hFFFF_FFFF) vcnt++;
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (rsp_valid && rsp_rdata == 32'hFFFF_FFFF) vcnt++;
        end
        check("t1_ready_cycles", cnt, 16);
        check("t1_init_reads", vcnt, 16);

        // 2: partial write then read-after-write, latency exactly 2
        cyc(1'b1, 1'b1, 4'd3, 32'h1234_5678, 4'b0101);
        cyc(1'b1, 1'b0, 4'd3, 32'd0, 4'hF);
        idle(1);
        check("t2_model_mem3", m_mem[3], 32'hFF34_FF78);
        idle(1);
        check("t2_valid_early", rsp_valid, 0);
        idle(1);
        check("t2_valid_lat2", rsp_valid, 1);
        check("t2_rdata", rsp_rdata, 32'hFF34_FF78);
        idle(3);

        // 3: back-to-back reads at full throughput
        t3_exp = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF34_FF78};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) cyc(1'b1, 1'b0, 4'(i), 32'd0, 4'hF);
            else idle(1);
            if (i < 4) check("t3_ready", req_ready, 1);
            if (i >= 3 && i <= 6) begin
                check("t3_valid", rsp_valid, 1);
                check("t3_rdata", rsp_rdata, t3_exp[i-3]);
            end
            if (i == 7) check("t3_valid_end", rsp_valid, 0);
        end

        // 4: backpressure, credit stall, hold and drain
        cyc(1'b1, 1'b1, 4'd1, 32'h0000_0011, 4'hF);
        cyc(1'b1, 1'b1, 4'd2, 32'h0000_0022, 4'hF);
        idle(3);
        rsp_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 4'(i + 1), 32'd0, 4'hF);
            if (req_ready) cnt++;
        end
        check("t4_accepted", cnt, 3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_rdata", rsp_rdata, 32'h0000_0011);
            check("t4_stalled", req_ready, 0);
        end
        idle(1);
        rsp_ready = 1'b1;
        #1;
        check("t4_ready_on_pop", req_ready, 1);
        check("t4_drain0", rsp_rdata, 32'h0000_0011);
        idle(1);
        check("t4_drain1", rsp_rdata, 32'h0000_0022);
        idle(1);
        check("t4_drain2", rsp_rdata, 32'hFF34_FF78);
        check("t4_drain2_valid", rsp_valid, 1);
        idle(1);
        check("t4_drained", rsp_valid, 0);

        // 5: full write to the top address, then a be=0 no-op write
        cyc(1'b1, 1'b1, 4'd15, 32'hA5A5_A5A5, 4'hF);
        cyc(1'b1, 1'b0, 4'd15, 32'd0, 4'hF);
        idle(3);
        check("t5_valid", rsp_valid, 1);
        check("t5_rdata", rsp_rdata, 32'hA5A5_A5A5);
        cyc(1'b1, 1'b1, 4'd15, 32'h0000_0000, 4'h0);
        cyc(1'b1, 1'b0, 4'd15, 32'd0, 4'hF);
        idle(3);
        check("t5_be0_valid", rsp_valid, 1);
        check("t5_be0_rdata", rsp_rdata, 32'hA5A5_A5A5);
        idle(3);

        // 6: reset with two reads in flight
        rsp_ready = 1'b0;
        cyc(1'b1, 1'b0, 4'd15, 32'd0, 4'hF);
        cyc(1'b1, 1'b0, 4'd3, 32'd0, 4'hF);
        idle(2);
        check("t6_pre_valid", rsp_valid, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_rdata", rsp_rdata, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_init_done", init_done, 0);
        rsp_ready = 1'b1;
        idle(2);
        reset_n = 1'b1;
        sweep_check("t6");
        cyc(1'b1, 1'b0, 4'd15, 32'd0, 4'hF);
        idle(3);
        check("t6_reinit_valid", rsp_valid, 1);
        check("t6_reinit_rdata", rsp_rdata, 32'hFFFF_FFFF);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
